// File: rtl/mem_demux_router_if.sv
// Source/consumer bundle of the memory data demultiplexer.
// drop_cnt exists only when DEMUX_DROP_CNT_EN is defined.
interface mem_demux_router_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned SEL_W  = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic                    err_sel;
  logic                    err_clr;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]              drop_cnt;
`endif

  // Router side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready, err_clr,
    output in_ready, out_valid, out_data, err_sel
`ifdef DEMUX_DROP_CNT_EN
    , output drop_cnt
`endif
  );

  // Source and consumers side.
  modport master (
    output in_valid, in_data, in_sel, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err_sel
`ifdef DEMUX_DROP_CNT_EN
    , input drop_cnt
`endif
  );
endinterface

// File: rtl/mem_demux_router.sv
// Registered 1-to-N memory data demultiplexer with one-word holding register
// per channel. Optional saturating drop counter under DEMUX_DROP_CNT_EN.
module mem_demux_chan #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Push beats pop so a word arriving as the old one leaves causes no bubble.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (push_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
    end else if (vld_q && pop_i) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

module mem_demux_router #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_demux_router_if.slave  bus
);
  logic [N_OUT-1:0]             vld;
  logic [N_OUT-1:0][DATA_W-1:0] data_pk;
  logic [N_OUT-1:0]             sel_oh;
  logic [N_OUT-1:0]             push;
  logic                         sel_hit;
  logic                         rdy;
  logic                         accept;
  logic                         drop;
  logic                         err_q, err_d;

  // Out-of-range selects are always ready so the source never stalls on them.
  always_comb begin
    sel_oh  = '0;
    sel_hit = 1'b0;
    rdy     = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_oh[k] = 1'b1;
        sel_hit   = 1'b1;
        rdy       = !vld[k] || bus.out_ready[k];
      end
    end
  end

  assign accept = bus.in_valid && rdy;
  assign drop   = accept && !sel_hit;
  assign push   = accept ? sel_oh : '0;

  genvar g;
  generate
    for (g = 0; g < N_OUT; g++) begin : g_chan
      mem_demux_chan #(.DATA_W(DATA_W)) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push[g]),
        .pop_i  (bus.out_ready[g]),
        .data_i (bus.in_data),
        .vld_o  (vld[g]),
        .data_o (data_pk[g])
      );
    end
  endgenerate

  // Set wins over clear so a drop coinciding with err_clr is never lost.
  always_comb begin
    err_d = err_q;
    if (drop)             err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // A drop on the clearing edge restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (drop) begin
      if (bus.err_clr)          cnt_d = 8'd1;
      else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
    end else if (bus.err_clr) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign bus.drop_cnt = cnt_q;
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_data  = data_pk;
  assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_mem_demux_router.sv
// Scoreboard bench for mem_demux_router: driver queues expected words per
// channel, a negedge monitor pops them as consumers take each word.
module tb_mem_demux_router;
  localparam int DW = 16;
  localparam int NO = 3;
  localparam int SW = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DW-1:0] q [NO][$];

  mem_demux_router_if #(.DATA_W(DW), .N_OUT(NO), .SEL_W(SW)) bus ();

  mem_demux_router #(.DATA_W(DW), .N_OUT(NO), .SEL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the word until accepted or the cycle budget expires.
  task automatic send(input logic [SW-1:0] sel, input logic [DW-1:0] d, input int maxc);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    while (!done && n < maxc) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (int'(sel) < NO) q[sel].push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout sel=%0d actual=stalled required=accepted", sel);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NO; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          checks++;
          if (q[k].size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected ch%0d actual=%0h required=none", k, bus.out_data[k*DW +: DW]);
          end else begin
            logic [DW-1:0] e;
            e = q[k].pop_front();
            if (bus.out_data[k*DW +: DW] !== e) begin
              errors++;
              $display("FAIL mon_data ch%0d actual=%0h required=%0h", k, bus.out_data[k*DW +: DW], e);
            end
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '1;
    bus.err_clr   = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 3'b000);
    chk("rst_out_data",  bus.out_data, 48'h0);
    chk("rst_err_sel",   bus.err_sel, 1'b0);
`ifdef DEMUX_DROP_CNT_EN
    chk("rst_drop_cnt",  bus.drop_cnt, 8'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single word to channel 1.
    send(2'd1, 16'hA5A5, 4);
    chk("t1_out_valid", bus.out_valid, 3'b010);
    chk("t1_ch1_data",  bus.out_data[1*DW +: DW], 16'hA5A5);
    chk("t1_ch0_data",  bus.out_data[0*DW +: DW], 16'h0000);
    chk("t1_ch2_data",  bus.out_data[2*DW +: DW], 16'h0000);
    tick();

    // Backpressure on channel 0, then release with no bubble.
    bus.out_ready[0] = 1'b0;
    send(2'd0, 16'h1111, 4);
    bus.in_sel = 2'd0;
    #1;
    chk("t2_ready_low", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h2222;
    tick();
    chk("t2_stall_ready", bus.in_ready, 1'b0);
    chk("t2_hold_data",   bus.out_data[0*DW +: DW], 16'h1111);
    bus.out_ready[0] = 1'b1;
    send(2'd0, 16'h2222, 4);
    chk("t2_no_bubble_vld", bus.out_valid[0], 1'b1);
    chk("t2_new_data",      bus.out_data[0*DW +: DW], 16'h2222);
    tick();

    // Streaming to channel 2.
    for (int i = 1; i <= 4; i++) begin
      bus.in_sel = 2'd2;
      #1;
      chk("t3_stream_ready", bus.in_ready, 1'b1);
      send(2'd2, DW'(i), 1);
      chk("t3_stream_data", bus.out_data[2*DW +: DW], 64'(i));
    end
    tick();
    tick();
    chk("t3_drained", bus.out_valid, 3'b000);

    // Out-of-range select is dropped and flagged.
    bus.in_sel = 2'd3;
    #1;
    chk("t4_drop_ready", bus.in_ready, 1'b1);
    send(2'd3, 16'hDEAD, 1);
    chk("t4_err_sel",    bus.err_sel, 1'b1);
    chk("t4_no_valid",   bus.out_valid, 3'b000);
`ifdef DEMUX_DROP_CNT_EN
    chk("t4_drop_cnt",   bus.drop_cnt, 8'd1);
`endif
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4_err_clr", bus.err_sel, 1'b0);
`ifdef DEMUX_DROP_CNT_EN
    chk("t4_cnt_clr", bus.drop_cnt, 8'd0);
    for (int i = 0; i < 300; i++) send(2'd3, DW'(i), 1);
    chk("t5_saturate", bus.drop_cnt, 8'd255);
`endif
    bus.err_clr = 1'b1;
    send(2'd3, 16'hBEEF, 1);
    bus.err_clr = 1'b0;
    chk("t5_set_wins", bus.err_sel, 1'b1);
`ifdef DEMUX_DROP_CNT_EN
    chk("t5_cnt_one", bus.drop_cnt, 8'd1);
`endif

    // Async reset with all channels full.
    bus.out_ready = '0;
    send(2'd0, 16'hAAAA, 2);
    send(2'd1, 16'hBBBB, 2);
    send(2'd2, 16'hCCCC, 2);
    chk("t6_full", bus.out_valid, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.out_valid, 3'b000);
    chk("t6_rst_data",  bus.out_data, 48'h0);
    chk("t6_rst_err",   bus.err_sel, 1'b0);
`ifdef DEMUX_DROP_CNT_EN
    chk("t6_rst_cnt",   bus.drop_cnt, 8'd0);
`endif
    for (int k = 0; k < NO; k++) q[k].delete();
    bus.out_ready = '1;
    #3;
    rst_n = 1'b1;
    tick();
    send(2'd1, 16'h5A5A, 2);
    chk("t7_after_rst", bus.out_valid, 3'b010);
    tick();
    tick();

    for (int k = 0; k < NO; k++) chk("end_queue_empty", 64'(q[k].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_demux_router.md
# mem_demux_router

Parametrised, registered 1-to-N demultiplexer that steers memory read/write data words from a single source onto one of N_OUT destination channels, each with its own valid/ready handshake and output holding register. It sits between the memory data port and the CPU consumers (register-file writeback, I/O, auxiliary units). Every output is a flop, so no latches are inferred. Out-of-range selects are dropped and flagged. Each channel buffers one word and sustains one transfer per cycle.

## Interface
Parameters:
- DATA_W, 16, width of data word
- N_OUT, 3, number of output channels (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_OUT

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  source word present
- in_ready  out  1  router accepts word this cycle
- in_data  in  DATA_W  source word
- in_sel  in  SEL_W  destination channel index
- out_valid  out  N_OUT  per-channel word present
- out_ready  in  N_OUT  per-channel consumer accepts
- out_data  out  N_OUT*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- err_sel  out  1  sticky: out-of-range select was dropped
- err_clr  in  1  clears err_sel (and drop counter when compiled in)

## Operation
- Reset values: out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0.
- Accept: a word is accepted when in_valid && in_ready is true on a rising edge.
- in_ready, combinational:
  - in_sel < N_OUT: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - in_sel >= N_OUT: in_ready = 1. The word is accepted and dropped.
- Channel k register, per edge:
  - Accept with in_sel == k: out_data[k] <= in_data, out_valid[k] <= 1.
  - Otherwise, if out_valid[k] && out_ready[k]: out_valid[k] <= 0. out_data[k] holds its last value.
  - Otherwise: hold.
- Simultaneous pop and push on the same channel: the new word replaces the old one and out_valid stays 1. No bubble.
- Only the selected channel changes on an accept. All other channels drain independently.
- Drop: an accepted word with in_sel >= N_OUT sets err_sel on the next edge. No channel is modified.
- err_clr and a drop on the same edge: set wins, so err_sel = 1.
- If 2**SEL_W == N_OUT, drops are impossible and err_sel stays 0.
- in_data and in_sel must stay stable while in_valid && !in_ready. The router does not check this.

## Timing
- Latency from accept to out_valid[k] = 1 with data: 1 cycle.
- Throughput: 1 word/cycle total, back-to-back to the same channel when its consumer holds out_ready = 1.
- in_ready has a combinational path from out_ready and in_sel only. It does not depend on in_valid.
- out_valid, out_data and err_sel come straight from flops.
- Asynchronous reset mid-transfer: all channels are emptied immediately. Any in-flight word is lost. No acceptance occurs on the edge at which rst_n deasserts.

## Configuration
- DEMUX_DROP_CNT_EN defined:
  - Adds output drop_cnt [7:0], counting dropped words.
  - Saturates at 255.
  - Cleared by err_clr. An increment on the same edge as err_clr wins, giving drop_cnt = 1.
  - Reset value 0.
- Undefined: no drop_cnt port and no counter logic. err_sel behaviour is unchanged.

## Test plan
- Reset, then in_sel=1, in_data=16'hA5A5, in_valid=1, all out_ready=1 -> next cycle out_valid=3'b010 and channel 1 data = A5A5. Channels 0 and 2 read 0.
- Channel 0 with out_ready[0]=0: push 16'h1111 -> in_ready for sel=0 drops to 0. A second push of 16'h2222 stalls. Raise out_ready[0] -> 2222 lands the next cycle with no bubble.
- Streaming to channel 2: 4 words 1,2,3,4 back-to-back with out_ready[2]=1 -> in_ready stays 1 and channel 2 shows 1,2,3,4 on consecutive cycles.
- in_sel=3 with N_OUT=3, in_valid=1 -> in_ready=1 and no out_valid change. err_sel=1 next cycle. With the macro defined, drop_cnt=1. Pulse err_clr -> err_sel=0 and drop_cnt=0.
- Saturation (macro defined): 300 drops -> drop_cnt=255. err_clr asserted together with a drop -> err_sel=1 and drop_cnt=1.
- Assert rst_n=0 asynchronously while out_valid=3'b111 -> all outputs are 0 before the next clock edge.
